ldm_stm_seq: RTL and testbench
==============================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Parameter: STEP, default 4, byte increment between consecutive transfer addresses.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-004 start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-005 is_load  in  1  1 = block load (memory to registers), 0 = block store (registers to memory).
REQ-006 base_reg  in  4  base register number.
REQ-007 base_val  in  32  current value of base register, valid in the cycle start is high.
REQ-008 reg_list  in  16  bit i set means register i is transferred.
REQ-009 up  in  1  1 = ascending addresses from base, 0 = descending.
REQ-010 pre  in  1  1 = step before the first access, 0 = step after.
REQ-011 wback  in  1  1 = write the final address to base_reg.
REQ-012 rf_ra  out  4  register-file read address during a store.
REQ-013 rf_rd  in  32  register-file read data for rf_ra (R15 value supplied by the register file).
REQ-014 rf_we / rf_wa / rf_wd  out  1/4/32  register-file write port (registers 0-14 only).
REQ-015 pc_we / pc_wd  out  1/32  R15 write strobe and data.
REQ-016 mem_req / mem_we / mem_addr / mem_wd  out  1/1/32/32  memory request.
REQ-017 mem_ready / mem_rdata  in  1/32  memory acknowledge and load data.
REQ-018 busy / done  out  1/1  operation in progress; one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, LATCH, XFER, WB and DONE.
REQ-020 IDLE: start=1 SHALL latch all command inputs and base_val, then go to LATCH; start in any other state SHALL be ignored.
REQ-021 LATCH: SHALL compute N = popcount(reg_list) and the start address (up&!pre: base; up&pre: base+STEP; !up&!pre: base-STEP*N+STEP; !up&pre: base-STEP*N), then go to XFER, or to DONE if N=0.
REQ-022 XFER: SHALL transfer the set registers in ascending register number at ascending addresses, starting at the start address, one register per accepted request.
REQ-023 In XFER, mem_req SHALL be 1 and mem_addr stable until mem_ready=1 is sampled; the address then advances by STEP and the next set register is selected.
REQ-024 Store: mem_we=1, rf_ra = current register, mem_wd = rf_rd; load: mem_we=0.
REQ-025 Load: in the mem_ready=1 cycle, rf_we=1, rf_wa = current register, rf_wd = mem_rdata; for register 15 instead pc_we=1, pc_wd = mem_rdata, rf_we=0.
REQ-026 After the last transfer, the FSM SHALL go to WB if wback=1, else to DONE.
REQ-027 WB: one cycle with rf_we=1, rf_wa = base_reg, rf_wd = base+STEP*N (up) or base-STEP*N (!up).
REQ-028 WB SHALL be skipped when a load list contains base_reg (the loaded value wins) or when base_reg=15.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 busy SHALL be 1 in LATCH, XFER, WB and DONE, and 0 in IDLE.
REQ-031 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around without error).
REQ-032 Latency: with mem_ready constantly 1, start to done SHALL take N+2 cycles, plus 1 cycle when WB is taken.
REQ-033 Outputs not named active for a state SHALL be 0 (rf_wa, rf_ra and the data buses SHALL be 0 whenever their strobe is 0).

Reset
REQ-034 reset=0 at a clock edge SHALL force IDLE in any state, abandoning a transfer in progress with no further rf_we, pc_we or mem_req.
REQ-035 Reset values SHALL be 0 for busy, done, mem_req, mem_we, rf_we, pc_we, and for all address and data outputs.

Verification
REQ-036 STM, reg_list=0x0007, base_reg=13, base_val=0x100, up=0, pre=1, wback=1, mem_ready=1 -> writes to 0xF4/0xF8/0xFC from R0/R1/R2; WB writes R13=0xF4; done at start+6.
REQ-037 LDM, reg_list=0x8001, base_reg=0, base_val=0x200, up=1, pre=0, wback=1 -> R0<=data@0x200; pc_we with data@0x204; WB skipped (R0 in list); done at start+4.
REQ-038 reg_list=0x0000, start -> no mem_req, no writes; done=1 two cycles after start.
REQ-039 STM with reg_list=0x0010 and mem_ready held 0 for 3 cycles -> mem_req and mem_addr stable for 4 cycles, a single transfer; start pulses meanwhile are ignored.
REQ-040 reset=0 during the second transfer of a 4-register LDM -> next cycle in IDLE with all outputs 0 and no further rf_we.
REQ-041 up=0, pre=1, base_val=0x4, reg_list=0x0003 -> addresses 0xFFFFFFFC and 0x00000000 (wrap-around).

Source files
------------

// File: rtl/ldm_stm_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_seq_if
// Brief    : Memory request/acknowledge bus used by the block-transfer sequencer.
// Revision : 1.0
// ============================================================================
interface ldm_stm_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wd,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wd,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_seq
// Brief    : Block load/store multiple sequencer (LDM/STM) with base write-back.
// Revision : 1.0
// ============================================================================
module ldm_stm_seq #(
  parameter int STEP = 4
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          start,
  input  wire          is_load,
  input  wire  [3:0]   base_reg,
  input  wire  [31:0]  base_val,
  input  wire  [15:0]  reg_list,
  input  wire          up,
  input  wire          pre,
  input  wire          wback,
  output logic [3:0]   rf_ra,
  input  wire  [31:0]  rf_rd,
  output logic         rf_we,
  output logic [3:0]   rf_wa,
  output logic [31:0]  rf_wd,
  output logic         pc_we,
  output logic [31:0]  pc_wd,
  ldm_stm_seq_if.master mem,
  output logic         busy,
  output logic         done
);

  localparam logic [31:0] c_step = 32'(STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_XFER  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_is_load;
  logic [3:0]  r_base_reg;
  logic [31:0] r_base;
  logic [15:0] r_list;
  logic        r_up;
  logic        r_pre;
  logic        r_wback;
  logic        r_skip_wb;
  logic [31:0] r_addr;
  logic [31:0] r_wb_val;
  logic [3:0]  r_cur;

  logic [4:0]  w_n;
  logic [31:0] w_span;
  logic [15:0] w_remain;

  function automatic logic [4:0] f_popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] f_lowest(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign w_n      = f_popcount(r_list);
  assign w_span   = c_step * {27'b0, w_n};
  assign w_remain = r_list & ~(16'd1 << r_cur);

  // r_list holds the original list in LATCH and is consumed bit by bit in XFER.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_base_reg <= '0;
      r_base     <= '0;
      r_list     <= '0;
      r_up       <= 1'b0;
      r_pre      <= 1'b0;
      r_wback    <= 1'b0;
      r_skip_wb  <= 1'b0;
      r_addr     <= '0;
      r_wb_val   <= '0;
      r_cur      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_load  <= is_load;
            r_base_reg <= base_reg;
            r_base     <= base_val;
            r_list     <= reg_list;
            r_up       <= up;
            r_pre      <= pre;
            r_wback    <= wback;
            r_state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_cur     <= f_lowest(r_list);
          r_wb_val  <= r_up ? (r_base + w_span) : (r_base - w_span);
          // A loaded base register keeps the loaded value; R15 is never written back.
          r_skip_wb <= !r_wback || (r_base_reg == 4'd15) || (r_is_load && r_list[r_base_reg]);
          case ({r_up, r_pre})
            2'b10:   r_addr <= r_base;
            2'b11:   r_addr <= r_base + c_step;
            2'b00:   r_addr <= r_base - w_span + c_step;
            default: r_addr <= r_base - w_span;
          endcase
          r_state <= (w_n == 5'd0) ? S_DONE : S_XFER;
        end
        S_XFER: begin
          if (mem.mem_ready) begin
            r_list <= w_remain;
            r_addr <= r_addr + c_step;
            r_cur  <= f_lowest(w_remain);
            if (w_remain == 16'd0) r_state <= r_skip_wb ? S_DONE : S_WB;
          end
        end
        S_WB:    r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; only the load write-back follows mem_ready.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = '0;
    mem.mem_wd   = '0;
    rf_ra        = '0;
    rf_we        = 1'b0;
    rf_wa        = '0;
    rf_wd        = '0;
    pc_we        = 1'b0;
    pc_wd        = '0;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    if (r_state == S_XFER) begin
      mem.mem_req  = 1'b1;
      mem.mem_addr = r_addr;
      mem.mem_we   = !r_is_load;
      if (!r_is_load) begin
        rf_ra      = r_cur;
        mem.mem_wd = rf_rd;
      end else if (mem.mem_ready) begin
        if (r_cur == 4'd15) begin
          pc_we = 1'b1;
          pc_wd = mem.mem_rdata;
        end else begin
          rf_we = 1'b1;
          rf_wa = r_cur;
          rf_wd = mem.mem_rdata;
        end
      end
    end
    if (r_state == S_WB) begin
      rf_we = 1'b1;
      rf_wa = r_base_reg;
      rf_wd = r_wb_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_stm_seq
// Brief    : Scoreboard bench for ldm_stm_seq with a list-level reference model.
// Revision : 1.0
// ============================================================================
module tb_ldm_stm_seq;
  localparam int STEP = 4;
  localparam int K_XFER = 0;
  localparam int K_WB   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rg;
    logic        we;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, is_load, up, pre, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we, pc_we, busy, done;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd, pc_wd;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rmode    = 0;
  exp_t q[$];
  exp_t m_e;

  ldm_stm_seq_if mif ();

  ldm_stm_seq #(.STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .up(up), .pre(pre), .wback(wback), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd),
    .mem(mif.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a ^ 32'h5EED_0000) + {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] rf_fn(input logic [3:0] r);
    return 32'hCAFE_0000 | {28'b0, r};
  endfunction

  always_comb mif.mem_rdata = mem_fn(mif.mem_addr);
  always_comb rf_rd = rf_fn(rf_ra);

  // rmode 0: always ready, 1: random ready, 2: driven by a directed test
  always @(posedge clk) begin
    #1;
    if (rmode == 0) mif.mem_ready = 1'b1;
    else if (rmode == 1) mif.mem_ready = ($urandom % 3) != 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: DUT event with no matching expectation (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer, write-back or done.
  always @(negedge clk) begin
    if (reset) begin
      if (!mif.mem_req) begin
        chk("idle_mem_addr", mif.mem_addr, 0);
        chk("idle_mem_we", mif.mem_we, 0);
      end
      if (!(mif.mem_req && mif.mem_we)) begin
        chk("rf_ra_zero", rf_ra, 0);
        chk("mem_wd_zero", mif.mem_wd, 0);
      end
      if (!rf_we) begin
        chk("rf_wa_zero", rf_wa, 0);
        chk("rf_wd_zero", rf_wd, 0);
      end
      if (!pc_we) chk("pc_wd_zero", pc_wd, 0);
      if (mif.mem_req && mif.mem_ready) begin
        if (q.size() == 0 || q[0].kind != K_XFER) unexpected("xfer");
        else begin
          m_e = q.pop_front();
          chk("xfer_addr", mif.mem_addr, m_e.addr);
          chk("xfer_we", mif.mem_we, m_e.we);
          if (m_e.we) begin
            chk("st_rf_ra", rf_ra, m_e.rg);
            chk("st_data", mif.mem_wd, m_e.data);
            chk("st_no_rf_we", rf_we, 0);
          end else if (m_e.rg == 4'd15) begin
            chk("ld_pc_we", pc_we, 1);
            chk("ld_pc_wd", pc_wd, m_e.data);
            chk("ld_pc_no_rf_we", rf_we, 0);
          end else begin
            chk("ld_rf_we", rf_we, 1);
            chk("ld_rf_wa", rf_wa, m_e.rg);
            chk("ld_rf_wd", rf_wd, m_e.data);
            chk("ld_no_pc_we", pc_we, 0);
          end
        end
      end else if (rf_we || pc_we) begin
        if (q.size() == 0 || q[0].kind != K_WB || pc_we) unexpected("write");
        else begin
          m_e = q.pop_front();
          chk("wb_wa", rf_wa, m_e.rg);
          chk("wb_wd", rf_wd, m_e.data);
        end
      end
      if (done) begin
        if (q.size() == 0 || q[0].kind != K_DONE) unexpected("done");
        else begin
          m_e = q.pop_front();
          if (m_e.cyc >= 0) chk("done_cycle", cyc, m_e.cyc);
        end
      end
    end
  end

  // Reference model: the transfer list, its addresses and the write-back value.
  task automatic launch(input logic ld, input logic [3:0] br, input logic [31:0] bv,
                        input logic [15:0] rl, input logic u, input logic p, input logic wb);
    int          n, k, do_wb;
    logic [31:0] span, lo;
    exp_t        e;
    @(posedge clk); #1;
    is_load = ld; base_reg = br; base_val = bv; reg_list = rl;
    up = u; pre = p; wback = wb; start = 1'b1;
    n    = $countones(rl);
    span = 32'(STEP * n);
    if (u) lo = p ? bv + 32'(STEP) : bv;
    else   lo = p ? bv - span : bv - span + 32'(STEP);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        e.kind = K_XFER; e.addr = lo + 32'(STEP * k); e.rg = 4'(i); e.we = !ld;
        e.data = ld ? mem_fn(e.addr) : rf_fn(4'(i)); e.cyc = -1;
        q.push_back(e);
        k++;
      end
    end
    do_wb = (wb && n != 0 && br != 4'd15 && !(ld && rl[br])) ? 1 : 0;
    if (do_wb != 0) begin
      e.kind = K_WB; e.addr = 0; e.rg = br; e.we = 0; e.cyc = -1;
      e.data = u ? bv + span : bv - span;
      q.push_back(e);
    end
    e.kind = K_DONE; e.addr = 0; e.data = 0; e.rg = 0; e.we = 0;
    e.cyc  = (rmode == 0) ? cyc + n + 2 + do_wb : -1;
    q.push_back(e);
    @(negedge clk) chk("busy_idle", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk) chk("busy_active", busy, 1);
  endtask

  // Waits for IDLE while firing stray start pulses that must be ignored.
  task automatic wait_done();
    bit fin;
    fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        start = 1'b0;
        fin = 1;
      end else begin
        start    = ($urandom % 4) == 0;
        base_val = $urandom;
        reg_list = 16'($urandom);
        is_load  = 1'($urandom);
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_timeout: busy still 1, required 0 within 400 cycles");
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      q.delete();
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bv;
    logic [15:0] rl;
    reset = 1'b0; start = 1'b0; is_load = 1'b0; base_reg = '0; base_val = '0;
    reg_list = '0; up = 1'b0; pre = 1'b0; wback = 1'b0; mif.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", |{rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd, mif.mem_req,
        mif.mem_we, mif.mem_addr, mif.mem_wd, busy, done}, 0);
    @(posedge clk); #1 reset = 1'b1;

    rmode = 0;
    launch(0, 4'd13, 32'h100, 16'h0007, 0, 1, 1); wait_done();
    launch(1, 4'd0,  32'h200, 16'h8001, 1, 0, 1); wait_done();
    launch(0, 4'd3,  32'h1234, 16'h0000, 1, 0, 1); wait_done();
    launch(0, 4'd2,  32'h4,   16'h0003, 0, 1, 0); wait_done();

    // Stalled single store: request and address must hold while ready is low.
    rmode = 2; mif.mem_ready = 1'b0;
    launch(0, 4'd5, 32'h3000, 16'h0010, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mif.mem_ready = (i == 3);
      start = (i != 3); is_load = 1'b1; reg_list = 16'hFFFF; base_val = $urandom;
      @(negedge clk);
      chk("stall_req", mif.mem_req, 1);
      chk("stall_addr", mif.mem_addr, 32'h3000);
    end
    @(posedge clk); #1 start = 1'b0; mif.mem_ready = 1'b1;
    wait_done();

    // Reset during the second transfer of a four-register load.
    mif.mem_ready = 1'b1;
    launch(1, 4'd2, 32'h1000, 16'h00F0, 1, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0; mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", |{rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd, mif.mem_req,
        mif.mem_we, mif.mem_addr, mif.mem_wd, busy, done}, 0);
    q.delete();
    reset = 1'b1; mif.mem_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rf_we", rf_we, 0);
      chk("abort_no_req", mif.mem_req, 0);
    end

    for (int t = 0; t < 40; t++) begin
      rmode = int'($urandom % 2);
      case ($urandom % 4)
        0:       rl = 16'h0000;
        1:       rl = 16'hFFFF;
        2:       rl = 16'd1 << ($urandom % 16);
        default: rl = 16'($urandom);
      endcase
      case ($urandom % 3)
        0:       bv = $urandom % 64;
        1:       bv = 32'hFFFF_FFC0 | ($urandom % 64);
        default: bv = $urandom;
      endcase
      launch(1'($urandom), 4'($urandom), bv, rl, 1'($urandom), 1'($urandom), 1'($urandom));
      wait_done();
    end
    rmode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
